// File: rtl/pe_pkg.sv
// Shared package for the PE load scheduler.
// Holds the default lane geometry and the scheduler state enumeration.
package pe_pkg;

    // Default lane data width and number of PE lanes.
    localparam int unsigned PE_DATA_WIDTH = 8;
    localparam int unsigned PE_DATA_DEPTH = 33;

    // Scheduler states: waiting for a frame, streaming beats, completion cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } pe_state_e;

endpackage

// File: rtl/pe_load_sched.sv
// pe_load_sched: streams a frame of cfg_len beats from a valid/ready source
// onto an external PE demux, one lane per beat, lanes 0..cfg_len-1 in order.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           request a frame (honoured in IDLE only)
//   abort           drop the current frame (honoured in LOAD only)
//   cfg_len         lanes in the frame, 1..DATA_DEPTH, sampled on accepted start
//   in_data         source data
//   in_valid        source data valid
//   in_ready        scheduler accepting data (decoded from state)
//   dmx_data        registered data to the demux
//   dmx_sel         registered demux lane select
//   dmx_en          registered demux enable, one cycle per delivered beat
//   busy            frame in progress (LOAD or DONE)
//   done            one-cycle pulse following the DONE state of a completed frame
//   err             one-cycle pulse after a start with an illegal cfg_len
module pe_load_sched
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
    parameter int unsigned DATA_DEPTH = PE_DATA_DEPTH,
    parameter int unsigned SEL_WIDTH  = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEL_WIDTH:0]    cfg_len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dmx_data,
    output logic [SEL_WIDTH-1:0]  dmx_sel,
    output logic                  dmx_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned LEN_W = SEL_WIDTH + 1;

    pe_state_e             state_q;
    logic [LEN_W-1:0]      len_q;
    logic [SEL_WIDTH-1:0]  idx_q;
    logic [SEL_WIDTH-1:0]  idx_d;
    logic [DATA_WIDTH-1:0] dmx_data_q;
    logic [SEL_WIDTH-1:0]  dmx_sel_q;
    logic                  dmx_en_q;
    logic                  done_q;
    logic                  err_q;

    logic                  beat_c;
    logic                  last_beat_c;
    logic                  len_ok_c;

    // Handshake, final-beat and length-legality decode.
    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign beat_c      = in_valid && in_ready;
    assign idx_d       = idx_q + SEL_WIDTH'(1);
    assign last_beat_c = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    assign len_ok_c    = (cfg_len != LEN_W'(0)) && (cfg_len <= LEN_W'(DATA_DEPTH));

    // Frame FSM together with the registered demux and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            dmx_data_q <= '0;
            dmx_sel_q  <= '0;
            dmx_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dmx_en_q <= 1'b0;
            err_q    <= 1'b0;
            // done follows the DONE state by one register stage.
            done_q   <= (state_q == ST_DONE);

            // A beat taken in the abort cycle is still delivered.
            if (beat_c) begin
                dmx_data_q <= in_data;
                dmx_sel_q  <= idx_q;
                dmx_en_q   <= 1'b1;
                idx_q      <= idx_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (len_ok_c) begin
                            len_q   <= cfg_len;
                            idx_q   <= '0;
                            state_q <= ST_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // Abort takes priority over completing on the final beat.
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (beat_c && last_beat_c) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dmx_data = dmx_data_q;
    assign dmx_sel  = dmx_sel_q;
    assign dmx_en   = dmx_en_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pe_load_sched.sv
// Self-checking bench for pe_load_sched: directed frames plus a random soak,
// compared every cycle against a lane-counting reference model.
module tb_pe_load_sched;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 33;
    localparam int unsigned SW    = $clog2(DEPTH);

    typedef struct {
        logic           st;
        logic           ab;
        logic [SW:0]    len;
        logic           v;
        logic [DW-1:0]  d;
        logic           rn;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [SW:0]   cfg_len;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dmx_data;
    logic [SW-1:0] dmx_sel;
    logic          dmx_en;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    pe_load_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cfg_len  (cfg_len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dmx_data (dmx_data),
        .dmx_sel  (dmx_sel),
        .dmx_en   (dmx_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Reference model: frame phase (0 idle, 1 streaming, 2 finishing),
    // lanes requested and lanes delivered so far.
    int            m_phase;
    int            m_len;
    int            m_cnt;
    logic          e_en;
    logic          e_done;
    logic          e_err;
    logic [SW-1:0] e_sel;
    logic [DW-1:0] e_data;

    logic [SW+DW+4:0] obs_vec;
    logic [SW+DW+4:0] exp_vec;
    assign obs_vec = {in_ready, busy, dmx_en, done, err, dmx_sel, dmx_data};
    assign exp_vec = {(m_phase == 1), (m_phase != 0), e_en, e_done, e_err, e_sel, e_data};

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;

    // Observed event history for the current scenario.
    int en_cnt, done_cnt, err_cnt, first_en_cyc, last_en_cyc, done_cyc;
    int last_sel;
    logic busy_seen;
    int sel_q[$];
    stim_t sq[$];

    function automatic stim_t mk(logic st, logic ab, int len, logic v, logic [DW-1:0] d, logic rn);
        stim_t s;
        s.st  = st;
        s.ab  = ab;
        s.len = (SW+1)'(len);
        s.v   = v;
        s.d   = d;
        s.rn  = rn;
        return s;
    endfunction

    task automatic clear_hist();
        en_cnt = 0; done_cnt = 0; err_cnt = 0;
        first_en_cyc = -1; last_en_cyc = -1; done_cyc = -1;
        last_sel = -1; busy_seen = 1'b0;
        sel_q.delete();
    endtask

    // Drive one cycle, advance the model, sample outputs #1 after the edge.
    task automatic tick(input stim_t s);
        logic beat;
        start    = s.st;
        abort    = s.ab;
        cfg_len  = s.len;
        in_valid = s.v;
        in_data  = s.d;
        rst_n    = s.rn;
        if (!s.rn) begin
            m_phase = 0; m_len = 0; m_cnt = 0;
            e_en = 1'b0; e_done = 1'b0; e_err = 1'b0; e_sel = '0; e_data = '0;
        end else begin
            beat   = (m_phase == 1) && s.v;
            e_en   = beat;
            if (beat) begin
                e_sel  = SW'(m_cnt);
                e_data = s.d;
            end
            e_err  = (m_phase == 0) && s.st && (s.len == 0 || int'(s.len) > DEPTH);
            e_done = (m_phase == 2);
            if (m_phase == 0) begin
                if (s.st && s.len != 0 && int'(s.len) <= DEPTH) begin
                    m_phase = 1; m_len = int'(s.len); m_cnt = 0;
                end
            end else if (m_phase == 1) begin
                if (beat) m_cnt++;
                if (s.ab) m_phase = 0;
                else if (m_cnt == m_len) m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (dmx_en) begin
            en_cnt++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
            last_en_cyc = cyc;
            last_sel = int'(dmx_sel);
            sel_q.push_back(int'(dmx_sel));
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) err_cnt++;
        if (busy) busy_seen = 1'b1;
    endtask

    task automatic test_reset();
        clear_hist();
        sq.delete();
        sq.push_back(mk(1, 0, 4, 1, 8'hAA, 0));
        sq.push_back(mk(0, 0, 0, 1, 8'h55, 0));
        foreach (sq[i]) begin
            tick(sq[i]);
            compared++;
            if (obs_vec !== {(SW+DW+5){1'b0}}) begin
                failed++;
                $display("FAIL reset cyc %0d: got %h need 0", cyc, obs_vec);
            end
        end
    endtask

    task automatic test_basic();
        clear_hist();
        sq.delete();
        sq.push_back(mk(1, 0, 4, 0, 8'h00, 1));
        for (int i = 0; i < 4; i++) sq.push_back(mk(0, 0, 0, 1, DW'(8'h11 + i), 1));
        for (int i = 0; i < 4; i++) sq.push_back(mk(0, 0, 0, 0, 8'h00, 1));
        foreach (sq[i]) begin
            tick(sq[i]);
            compared++;
            if (obs_vec !== exp_vec) begin
                failed++;
                $display("FAIL basic cyc %0d: got %h need %h", cyc, obs_vec, exp_vec);
            end
        end
        compared++;
        if (en_cnt !== 4 || last_en_cyc - first_en_cyc !== 3) begin
            failed++;
            $display("FAIL basic_burst: got %0d pulses span %0d need 4 span 3", en_cnt, last_en_cyc - first_en_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (i >= sel_q.size() || sel_q[i] !== i) begin
                failed++;
                $display("FAIL basic_sel%0d: got %0d need %0d", i, (i < sel_q.size()) ? sel_q[i] : -1, i);
            end
        end
        compared++;
        if (done_cnt !== 1 || done_cyc !== last_en_cyc + 1) begin
            failed++;
            $display("FAIL basic_done: got cnt %0d cyc %0d need cnt 1 cyc %0d", done_cnt, done_cyc, last_en_cyc + 1);
        end
    endtask

    task automatic test_full_toggle();
        clear_hist();
        sq.delete();
        sq.push_back(mk(1, 0, 33, 0, 8'h00, 1));
        for (int i = 0; i < 80; i++) sq.push_back(mk(0, 0, 0, (i % 2) == 0, DW'($urandom), 1));
        foreach (sq[i]) begin
            tick(sq[i]);
            compared++;
            if (obs_vec !== exp_vec) begin
                failed++;
                $display("FAIL full cyc %0d: got %h need %h", cyc, obs_vec, exp_vec);
            end
        end
        compared++;
        if (en_cnt !== 33 || last_sel !== 32 || done_cnt !== 1) begin
            failed++;
            $display("FAIL full_frame: got %0d beats last sel %0d dones %0d need 33/32/1", en_cnt, last_sel, done_cnt);
        end
    endtask

    task automatic test_illegal_len();
        int lens[2];
        lens[0] = 0;
        lens[1] = 34;
        foreach (lens[k]) begin
            clear_hist();
            sq.delete();
            sq.push_back(mk(1, 0, lens[k], 1, 8'h3C, 1));
            for (int i = 0; i < 3; i++) sq.push_back(mk(0, 0, 0, 1, 8'h3C, 1));
            foreach (sq[i]) begin
                tick(sq[i]);
                compared++;
                if (obs_vec !== exp_vec) begin
                    failed++;
                    $display("FAIL illegal%0d cyc %0d: got %h need %h", lens[k], cyc, obs_vec, exp_vec);
                end
            end
            compared++;
            if (err_cnt !== 1 || en_cnt !== 0 || busy_seen !== 1'b0) begin
                failed++;
                $display("FAIL illegal%0d_sum: got err %0d beats %0d busy %0b need 1/0/0", lens[k], err_cnt, en_cnt, busy_seen);
            end
        end
    endtask

    task automatic test_abort();
        clear_hist();
        sq.delete();
        sq.push_back(mk(1, 0, 8, 0, 8'h00, 1));
        for (int i = 0; i < 3; i++) sq.push_back(mk(0, 0, 0, 1, DW'($urandom), 1));
        sq.push_back(mk(0, 1, 0, 1, DW'($urandom), 1));
        for (int i = 0; i < 4; i++) sq.push_back(mk(0, 0, 0, 1, DW'($urandom), 1));
        foreach (sq[i]) begin
            tick(sq[i]);
            compared++;
            if (obs_vec !== exp_vec) begin
                failed++;
                $display("FAIL abort cyc %0d: got %h need %h", cyc, obs_vec, exp_vec);
            end
        end
        compared++;
        if (en_cnt !== 4 || last_sel !== 3 || done_cnt !== 0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL abort_sum: got beats %0d last %0d dones %0d rdy %0b need 4/3/0/0", en_cnt, last_sel, done_cnt, in_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_hist();
        sq.delete();
        sq.push_back(mk(1, 0, 10, 0, 8'h00, 1));
        for (int i = 0; i < 5; i++) sq.push_back(mk(0, 0, 0, 1, DW'($urandom), 1));
        sq.push_back(mk(0, 0, 0, 1, 8'hEE, 0));
        sq.push_back(mk(1, 0, 2, 0, 8'h00, 1));
        for (int i = 0; i < 2; i++) sq.push_back(mk(0, 0, 0, 1, DW'($urandom), 1));
        for (int i = 0; i < 3; i++) sq.push_back(mk(0, 0, 0, 0, 8'h00, 1));
        foreach (sq[i]) begin
            tick(sq[i]);
            compared++;
            if (obs_vec !== exp_vec) begin
                failed++;
                $display("FAIL rstmid cyc %0d: got %h need %h", cyc, obs_vec, exp_vec);
            end
            if (sq[i].rn == 1'b0) begin
                compared++;
                if (obs_vec !== {(SW+DW+5){1'b0}}) begin
                    failed++;
                    $display("FAIL rstmid_zero: got %h need 0", obs_vec);
                end
            end
        end
        compared++;
        if (en_cnt !== 7 || last_sel !== 1 || done_cnt !== 1) begin
            failed++;
            $display("FAIL rstmid_sum: got beats %0d last %0d dones %0d need 7/1/1", en_cnt, last_sel, done_cnt);
        end
    endtask

    task automatic test_start_in_load();
        clear_hist();
        sq.delete();
        sq.push_back(mk(1, 0, 5, 0, 8'h00, 1));
        for (int i = 0; i < 2; i++) sq.push_back(mk(0, 0, 0, 1, DW'($urandom), 1));
        sq.push_back(mk(1, 0, 3, 1, DW'($urandom), 1));
        for (int i = 0; i < 6; i++) sq.push_back(mk(0, 0, 0, 1, DW'($urandom), 1));
        foreach (sq[i]) begin
            tick(sq[i]);
            compared++;
            if (obs_vec !== exp_vec) begin
                failed++;
                $display("FAIL startload cyc %0d: got %h need %h", cyc, obs_vec, exp_vec);
            end
        end
        compared++;
        if (en_cnt !== 5 || last_sel !== 4 || done_cnt !== 1) begin
            failed++;
            $display("FAIL startload_sum: got beats %0d last %0d dones %0d need 5/4/1", en_cnt, last_sel, done_cnt);
        end
    endtask

    task automatic test_random();
        clear_hist();
        sq.delete();
        for (int i = 0; i < 600; i++)
            sq.push_back(mk(($urandom % 6) == 0, ($urandom % 15) == 0, int'($urandom_range(0, 36)),
                            ($urandom % 3) != 0, DW'($urandom), ($urandom % 120) != 0));
        foreach (sq[i]) begin
            tick(sq[i]);
            compared++;
            if (obs_vec !== exp_vec) begin
                failed++;
                $display("FAIL random cyc %0d: got %h need %h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_len = '0; in_valid = 1'b0; in_data = '0;
        m_phase = 0; m_len = 0; m_cnt = 0;
        e_en = 1'b0; e_done = 1'b0; e_err = 1'b0; e_sel = '0; e_data = '0;
        test_reset();
        test_basic();
        test_full_toggle();
        test_illegal_len();
        test_abort();
        test_reset_mid_frame();
        test_start_in_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
